// File: rtl/cbb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cbb_rr_arbiter
//   Round-robin arbiter producing the registered one-hot select for CBB_MUX.
//   A grant is held stable until the downstream consumer accepts it. Priority
//   then rotates to the requester after the one just served.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  [N-1:0]     per-requester valid
//   req_ready  [N-1:0]     per-requester accept (one-hot or zero, combinational)
//   sel        [N-1:0]     registered one-hot grant, drives CBB_MUX sel
//   grant_idx  [IDX_W-1:0] binary index of the set bit in sel (0 when idle)
//   out_valid  1           a grant is held
//   out_ready  1           downstream accepts the muxed data this cycle
//
// States
//   state | meaning
//   IDLE  | no grant held, sel = 0
//   GRANT | sel holds exactly one requester until out_ready
// ---------------------------------------------------------------------------
module cbb_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     sel,
  output logic [IDX_W-1:0] grant_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] search_ptr;
  logic [N-1:0]     search_mask;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  logic             accept;

  assign out_valid = (state == GRANT);
  assign accept    = out_valid & out_ready;
  assign req_ready = sel & {N{accept}};

  assign next_ptr = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

  // In GRANT the search is only used on a handshake; the just-accepted
  // requester is masked so a back-to-back winner is always someone else.
  always_comb begin
    if (state == GRANT) begin
      search_mask = req_valid & ~sel;
      search_ptr  = next_ptr;
    end else begin
      search_mask = req_valid;
      search_ptr  = ptr;
    end
  end

  // Scan from the highest rotation offset down so the lowest offset from
  // search_ptr (the highest-priority set bit) is the last one written.
  always_comb begin : win_search
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, search_ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) begin
        pos = pos - (IDX_W + 1)'(N);
      end
      idx = pos[IDX_W-1:0];
      if (search_mask[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_onehot = {{(N - 1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            sel       <= win_onehot;
            grant_idx <= win_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready) begin
            ptr <= next_ptr;
            if (win_found) begin
              sel       <= win_onehot;
              grant_idx <= win_idx;
            end else begin
              sel       <= '0;
              grant_idx <= '0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          sel       <= '0;
          grant_idx <= '0;
        end
      endcase
    end
  end

endmodule
